// File: rtl/seg_scan_drv.sv
// seg_scan_drv
// Two-digit multiplexed seven-segment display driver. An 8-bit value is
// accepted into a pending register and copied to the display register only
// at a scan-frame boundary, so both digits always show the same value. The
// two digits are time-multiplexed, hex decoded, and dimmed by a 16-level
// PWM on the digit enable.
//
// Ports:
//   clk_in      : system clock, rising edge
//   btn_reset   : asynchronous active-low reset
//   value       : [7:4] high digit, [3:0] low digit
//   value_valid : upstream offers value this cycle
//   value_ready : pending register empty, value can be accepted
//   dp          : decimal point enables, [1] high digit, [0] low digit (live)
//   brightness  : PWM duty level 0..15, latched at each slot start
//   blank_lz    : blank the high digit's segments when it is 0
//   seg_led_h   : high digit word {enable, dp_n, seg_n[6:0] (g..a)}
//   seg_led_l   : low digit word, same encoding
//
// Handshake (valid/ready): a transfer happens on a rising edge where
// value_valid && value_ready. value_ready is simply "pending register empty";
// while it is low, value_valid is ignored and upstream must hold value stable.
// The pending value commits to the display at the frame boundary, and
// value_ready returns high on the cycle after that commit.
module seg_scan_drv #(
  parameter int SCAN_PERIOD = 93750
) (
  input  logic       clk_in,
  input  logic       btn_reset,
  input  logic [7:0] value,
  input  logic       value_valid,
  output logic       value_ready,
  input  logic [1:0] dp,
  input  logic [3:0] brightness,
  input  logic       blank_lz,
  output logic [8:0] seg_led_h,
  output logic [8:0] seg_led_l
);

  localparam int CNT_W   = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int SUB_LEN = SCAN_PERIOD / 16;
  localparam int PRE_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SUB_LEN - 1);

  localparam logic [8:0] WORD_OFF  = 9'h0FF;

  // Scan phase: which digit owns the current slot.
  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  // pre_q/sub_q track slot_cnt / SUB_LEN without a divider. sub_q saturates
  // at 15 so a period that is not a multiple of 16 still gives 100% duty at
  // brightness 15 for the few leftover cycles at the end of a slot.
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       sub_q, sub_d;
  logic [3:0]       bright_q, bright_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       disp_q, disp_d;
  logic [8:0]       seg_h_q, seg_h_d;
  logic [8:0]       seg_l_q, seg_l_d;

  logic             slot_last;
  logic             frame_end;
  logic             accept;
  logic             commit;
  logic             pwm_on;
  logic [6:0]       hi_seg;
  logic [6:0]       lo_seg;

  // Active-low segment pattern g..a for a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_last = (slot_cnt_q == SLOT_LAST);
    frame_end = slot_last && (phase_q == PH_LOW);
    accept    = value_valid && !pend_full_q;
    commit    = frame_end && pend_full_q;

    slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
    phase_d    = phase_q;
    if (slot_last) begin
      phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
    end

    pre_d = pre_q;
    sub_d = sub_q;
    if (slot_last) begin
      pre_d = '0;
      sub_d = 4'd0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      sub_d = (sub_q == 4'd15) ? sub_q : sub_q + 4'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    bright_d = (slot_cnt_q == '0) ? brightness : bright_q;

    // accept and commit are mutually exclusive: one needs pend_full low,
    // the other needs it high.
    pend_d      = accept ? value : pend_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (commit) begin
      pend_full_d = 1'b0;
    end
    disp_d = commit ? pend_q : disp_q;

    pwm_on = (sub_q <= bright_q);
    hi_seg = (blank_lz && (disp_q[7:4] == 4'h0)) ? 7'h7F : hex7(disp_q[7:4]);
    lo_seg = hex7(disp_q[3:0]);

    seg_h_d = WORD_OFF;
    seg_l_d = WORD_OFF;
    if (pwm_on && (phase_q == PH_HIGH)) begin
      seg_h_d = {1'b1, ~dp[1], hi_seg};
    end
    if (pwm_on && (phase_q == PH_LOW)) begin
      seg_l_d = {1'b1, ~dp[0], lo_seg};
    end
  end

  always_ff @(posedge clk_in or negedge btn_reset) begin
    if (!btn_reset) begin
      phase_q     <= PH_HIGH;
      slot_cnt_q  <= '0;
      pre_q       <= '0;
      sub_q       <= 4'd0;
      bright_q    <= 4'd15;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      disp_q      <= 8'h00;
      seg_h_q     <= 9'h1C0;
      seg_l_q     <= WORD_OFF;
    end else begin
      phase_q     <= phase_d;
      slot_cnt_q  <= slot_cnt_d;
      pre_q       <= pre_d;
      sub_q       <= sub_d;
      bright_q    <= bright_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      seg_h_q     <= seg_h_d;
      seg_l_q     <= seg_l_d;
    end
  end

  assign value_ready = ~pend_full_q;
  assign seg_led_h   = seg_h_q;
  assign seg_led_l   = seg_l_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Testbench for seg_scan_drv with SCAN_PERIOD=32. A driver issues one cycle
// of stimulus at a time and pushes the expected output words for the edge
// that follows; a monitor pops and compares on every falling edge.
module tb_seg_scan_drv;

  localparam int SP = 32;

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       btn_reset = 1'b1;
  logic [7:0] value = 8'h00;
  logic       value_valid = 1'b0;
  logic       value_ready;
  logic [1:0] dp = 2'b00;
  logic [3:0] brightness = 4'd15;
  logic       blank_lz = 1'b0;
  logic [8:0] seg_led_h;
  logic [8:0] seg_led_l;

  always #5 clk_in = ~clk_in;

  seg_scan_drv #(.SCAN_PERIOD(SP)) dut (
    .clk_in      (clk_in),
    .btn_reset   (btn_reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .dp          (dp),
    .brightness  (brightness),
    .blank_lz    (blank_lz),
    .seg_led_h   (seg_led_h),
    .seg_led_l   (seg_led_l)
  );

  // ---------------- scoreboard state ----------------
  logic [18:0] exp_q[$];     // {value_ready, seg_led_h, seg_led_l}
  logic [7:0]  src_q[$];     // values waiting to be offered upstream
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  // Reference model: the display as seen by a user. Time is just the number
  // of edges k since reset release; slot, phase and PWM step follow from it.
  int          k;
  logic [7:0]  m_disp;
  logic [7:0]  m_pend;
  bit          m_full;
  logic [3:0]  m_bright;
  logic [6:0]  dec_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    m_disp   = 8'h00;
    m_pend   = 8'h00;
    m_full   = 1'b0;
    m_bright = 4'd15;
  endtask

  // Predict the outputs after the coming edge and advance the model.
  task automatic model_push();
    int         cnt;
    int         ph;
    int         sub;
    bit         on;
    logic [6:0] hs;
    logic [8:0] eh;
    logic [8:0] el;
    cnt = k % SP;
    ph  = (k / SP) % 2;
    sub = cnt / (SP / 16);
    if (sub > 15) sub = 15;
    on  = (sub <= int'(m_bright));
    hs  = (blank_lz && (m_disp[7:4] == 4'h0)) ? 7'h7F : dec_tab[m_disp[7:4]];
    eh  = (ph == 0 && on) ? {1'b1, ~dp[1], hs} : 9'h0FF;
    el  = (ph == 1 && on) ? {1'b1, ~dp[0], dec_tab[m_disp[3:0]]} : 9'h0FF;
    if ((cnt == SP - 1) && (ph == 1) && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (value_valid && !m_full) begin
      m_pend = value;
      m_full = 1'b1;
      void'(src_q.pop_front());
    end
    if (cnt == 0) m_bright = brightness;
    exp_q.push_back({~m_full, eh, el});
    k++;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    value_valid = (src_q.size() != 0);
    value       = value_valid ? src_q[0] : 8'($urandom_range(0, 255));
    model_push();
    @(posedge clk_in);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        dp         = 2'($urandom_range(0, 3));
        brightness = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 40) == 0) src_q.push_back(8'($urandom_range(0, 255)));
      end
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_h"}, seg_led_h, 9'h1C0);
    check({tag, "_seg_l"}, seg_led_l, 9'h0FF);
    check({tag, "_ready"}, {8'h00, value_ready}, 9'h001);
  endtask

  // Release on a posedge+1 so the next edge is the first counted one.
  task automatic release_reset();
    @(posedge clk_in);
    #1;
    btn_reset = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL exp_queue at %0t: got empty queue, expected an entry", $time);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("seg_led_h", seg_led_h, e[17:9]);
        check("seg_led_l", seg_led_l, e[8:0]);
        check("value_ready", {8'h00, value_ready}, {8'h00, e[18]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    #2 btn_reset = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs("reset_held");
    release_reset();

    // Idle: "00" shown, enable moves to the low digit after one slot.
    run_cycles(2 * SP + 8, 1'b0);

    // Single handshake mid-phase 0.
    run_cycles(10, 1'b0);
    src_q.push_back(8'h3A);
    run_cycles(3 * SP, 1'b0);

    // Back-to-back values with valid held: 0x22 waits for 0x11 to commit.
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    run_cycles(7 * SP, 1'b0);

    // Leading-zero blanking with the high dp lit; dp[0]=0 keeps the low dp off.
    blank_lz = 1'b1;
    dp       = 2'b10;
    src_q.push_back(8'h05);
    run_cycles(5 * SP, 1'b0);
    blank_lz = 1'b0;
    dp       = 2'b00;

    // PWM at level 3 (8 of 32 cycles per slot), then back to full.
    brightness = 4'd3;
    run_cycles(4 * SP + 5, 1'b0);
    brightness = 4'd15;
    run_cycles(3 * SP, 1'b0);

    // Randomized traffic.
    run_cycles(1500, 1'b1);
    brightness = 4'd15;
    blank_lz   = 1'b0;
    dp         = 2'b00;
    src_q.delete();
    run_cycles(4 * SP, 1'b0);

    // Mid-operation reset while a value is pending: it must never be shown.
    src_q.push_back(8'h77);
    guard = 0;
    step();
    while (!m_full && guard < 10) begin
      step();
      guard++;
    end
    if (!m_full) begin
      n_cmp++;
      n_err++;
      $display("FAIL pend_wait: got no accept within 10 cycles, expected accept");
    end
    @(negedge clk_in);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    src_q.delete();
    btn_reset = 1'b0;
    #1 check_reset_outputs("reset_mid");
    repeat (3) @(posedge clk_in);
    release_reset();
    run_cycles(4 * SP, 1'b0);

    @(negedge clk_in);
    #1;
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL exp_queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
